// File: rtl/ro_meas_sequencer.sv
// Ring-oscillator measurement sequencer: clear, gate one RO, settle, capture a twice-seen count.
// Result and done appear CLR_CYC+G+SETTLE_CYC+3 cycles after start; no backpressure, start ignored while busy.
module ro_meas_sequencer #(
   parameter int N_RO       = 4,
   parameter int SEL_W      = 2,
   parameter int GATE_W     = 16,
   parameter int CNT_W      = 16,
   parameter int CLR_CYC    = 2,
   parameter int SETTLE_CYC = 4,
   parameter int CAPT_MAX   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              scan,
   input  logic              abort,
   input  logic [SEL_W-1:0]  ro_sel,
   input  logic [GATE_W-1:0] gate_cycles,
   input  logic [CNT_W-1:0]  ro_cnt,
   output logic [N_RO-1:0]   ro_en,
   output logic              cnt_clr,
   output logic              busy,
   output logic              res_valid,
   output logic [CNT_W-1:0]  res,
   output logic [SEL_W-1:0]  res_idx,
   output logic              res_err,
   output logic              done
);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_SETTLE, S_CAPT, S_NEXT} state_t;

   localparam logic [GATE_W-1:0] CLR_LD   = GATE_W'(CLR_CYC - 1);
   localparam logic [GATE_W-1:0] SET_LD   = GATE_W'(SETTLE_CYC - 1);
   localparam logic [GATE_W-1:0] CAPT_LD  = GATE_W'(CAPT_MAX - 1);
   localparam logic [SEL_W:0]    N_RO_W   = (SEL_W+1)'(N_RO);
   localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(N_RO - 1);

   state_t            state, nstate;
   logic [GATE_W-1:0] cnt, ncnt;
   logic [SEL_W-1:0]  idx, nidx;
   logic [GATE_W-1:0] gate_q;
   logic              scan_q;
   logic [CNT_W-1:0]  prev;
   logic              have_prev;
   logic              err_pulse;
   logic              go, bad_sel, match, last;

   always_comb begin
      nstate  = state;
      ncnt    = cnt;
      nidx    = idx;
      go      = 1'b0;
      bad_sel = 1'b0;
      match   = 1'b0;
      last    = !scan_q || (idx == LAST_IDX);
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               if (!scan && ({1'b0, ro_sel} >= N_RO_W)) begin
                  bad_sel = 1'b1;
               end else begin
                  go     = 1'b1;
                  nstate = S_CLR;
                  ncnt   = CLR_LD;
                  nidx   = scan ? '0 : ro_sel;
               end
            end
         end
         S_CLR: begin
            if (cnt == '0) begin
               nstate = S_RUN;
               ncnt   = gate_q - 1'b1;
            end else begin
               ncnt = cnt - 1'b1;
            end
         end
         S_RUN: begin
            if (cnt == '0) begin
               nstate = S_SETTLE;
               ncnt   = SET_LD;
            end else begin
               ncnt = cnt - 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt == '0) begin
               nstate = S_CAPT;
               ncnt   = CAPT_LD;
            end else begin
               ncnt = cnt - 1'b1;
            end
         end
         S_CAPT: begin
            // ro_cnt is asynchronous: accept it only once two consecutive samples agree
            match = have_prev && (ro_cnt == prev);
            if (match || cnt == '0) begin
               nstate = S_NEXT;
            end else begin
               ncnt = cnt - 1'b1;
            end
         end
         S_NEXT: begin
            if (!last) begin
               nstate = S_CLR;
               ncnt   = CLR_LD;
               nidx   = idx + 1'b1;
            end else begin
               nstate = S_IDLE;
            end
         end
         default: nstate = S_IDLE;
      endcase
      if (abort && state != S_IDLE) begin
         nstate = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         idx       <= '0;
         gate_q    <= '0;
         scan_q    <= 1'b0;
         prev      <= '0;
         have_prev <= 1'b0;
         err_pulse <= 1'b0;
         ro_en     <= '0;
         cnt_clr   <= 1'b0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         res       <= '0;
         res_idx   <= '0;
         res_err   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= nstate;
         cnt       <= ncnt;
         idx       <= nidx;
         prev      <= ro_cnt;
         have_prev <= (state == S_CAPT);
         err_pulse <= bad_sel;
         if (go) begin
            scan_q <= scan;
            gate_q <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
         end
         // Outputs are decoded from the next state so they line up with the state they describe
         ro_en     <= (nstate == S_RUN) ? (N_RO'(1) << nidx) : '0;
         cnt_clr   <= (nstate == S_CLR);
         busy      <= (nstate != S_IDLE);
         res_valid <= (nstate == S_NEXT);
         done      <= (nstate == S_NEXT) && last;
         if (state == S_CAPT && nstate == S_NEXT) begin
            res     <= match ? ro_cnt : '1;
            res_err <= !match;
            res_idx <= idx;
         end else if (bad_sel) begin
            res_err <= 1'b1;
         end else if (err_pulse) begin
            res_err <= 1'b0;
         end
      end
   end

endmodule
